// File: rtl/plc_timer_bank.sv
// plc_timer_bank: multi-channel PLC on-delay timer bank with manual pass-through and global E-stop.
// Optional off-delay hold is enabled by defining PLC_OFFDLY_EN.
module plc_timer_bank #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int PRESCALE       = 50000,
    parameter int DEFAULT_PRESET = 20,
    parameter int OFF_TICKS      = 10,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              estop,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] man,
    input  logic [NUM_CH-1:0] auto_md,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_preset,
    output logic [NUM_CH-1:0] ctrl,
    output logic [NUM_CH-1:0] busy
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef PLC_OFFDLY_EN
    localparam int HOLD_N = OFF_TICKS;
`else
    localparam int HOLD_N = 0;
`endif
    localparam logic [1:0] IDLE = 2'd0, TIMING = 2'd1, ON = 2'd2, OFF_HOLD = 2'd3;

    logic [PS_W-1:0]                ps_q, ps_d;
    logic [NUM_CH-1:0][1:0]         st_q, st_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   pre_q, pre_d;
    logic [NUM_CH-1:0]              ctrl_q, ctrl_d;
    logic                           tick;

    assign tick = (ps_q == PS_W'(PRESCALE - 1));
    assign ps_d = !ena ? ps_q : tick ? '0 : ps_q + PS_W'(1);

    // State register: prescaler, channel FSMs, counters, presets and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q   <= '0;
            st_q   <= '0;
            cnt_q  <= '0;
            pre_q  <= {NUM_CH{CNT_W'(DEFAULT_PRESET)}};
            ctrl_q <= '0;
        end else begin
            ps_q   <= ps_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            ctrl_q <= ctrl_d;
        end
    end

    // Next state per channel: estop and mode selection override the auto timer FSM.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        pre_d = pre_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ena) begin
                if (cfg_we && 32'(cfg_ch) == i)
                    pre_d[i] = cfg_preset;
                if (estop || man[i] || !auto_md[i]) begin
                    st_d[i]  = IDLE;
                    cnt_d[i] = '0;
                end else begin
                    case (st_q[i])
                        IDLE: if (start[i]) begin
                            st_d[i]  = (pre_q[i] == '0) ? ON : TIMING;
                            cnt_d[i] = '0;
                        end
                        TIMING: if (!start[i]) begin
                            st_d[i]  = IDLE;
                            cnt_d[i] = '0;
                        end else if (tick) begin
                            st_d[i]  = ({1'b0, cnt_q[i]} + 1'b1 >= {1'b0, pre_q[i]}) ? ON : TIMING;
                            cnt_d[i] = (st_d[i] == ON) ? '0 : cnt_q[i] + CNT_W'(1);
                        end
                        ON: if (!start[i]) begin
                            st_d[i]  = (HOLD_N == 0) ? IDLE : OFF_HOLD;
                            cnt_d[i] = '0;
                        end
                        default: if (start[i]) begin
                            st_d[i]  = ON;
                            cnt_d[i] = '0;
                        end else if (tick) begin
                            st_d[i]  = ({1'b0, cnt_q[i]} + 1'b1 >= (CNT_W+1)'(HOLD_N)) ? IDLE : OFF_HOLD;
                            cnt_d[i] = (st_d[i] == IDLE) ? '0 : cnt_q[i] + CNT_W'(1);
                        end
                    endcase
                end
            end
        end
    end

    // Outputs: manual follows start, auto drives from the next FSM state, estop forces off.
    always_comb begin
        ctrl_d = ctrl_q;
        busy   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ena)
                ctrl_d[i] = estop ? 1'b0 : man[i] ? start[i] : (st_d[i] == ON || st_d[i] == OFF_HOLD);
            busy[i] = (st_q[i] == TIMING || st_q[i] == OFF_HOLD);
        end
    end

    assign ctrl = ctrl_q;
endmodule

// File: tb/tb_plc_timer_bank.sv
// tb_plc_timer_bank: randomized scoreboard bench for two timer banks (PRESCALE 1 and 3) against a tick-level model.
module tb_plc_timer_bank;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int DEF    = 6;
    localparam int OFFT   = 4;
`ifdef PLC_OFFDLY_EN
    localparam int HOLD = OFFT;
`else
    localparam int HOLD = 0;
`endif

    logic clk = 0, reset = 1, ena = 0, estop = 0, cfg_we = 0;
    logic [NUM_CH-1:0] start = 0, man = 0, auto_md = 0;
    logic [1:0] cfg_ch = 0;
    logic [CNT_W-1:0] cfg_preset = 0;
    logic [NUM_CH-1:0] ctrl0, busy0, ctrl1, busy1;

    int checks = 0, errors = 0;
    logic [4*NUM_CH-1:0] exp_q[$];
    bit run = 0;

    int pr[2] = '{1, 3};
    int ph[2][NUM_CH], el[2][NUM_CH], pre[2][NUM_CH], ps[2];
    bit mc[2][NUM_CH];

    always #5 clk = ~clk;

    plc_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(1), .DEFAULT_PRESET(DEF), .OFF_TICKS(OFFT)) u0 (
        .clk(clk), .reset(reset), .ena(ena), .estop(estop), .start(start), .man(man), .auto_md(auto_md),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_preset(cfg_preset), .ctrl(ctrl0), .busy(busy0));
    plc_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(3), .DEFAULT_PRESET(DEF), .OFF_TICKS(OFFT)) u1 (
        .clk(clk), .reset(reset), .ena(ena), .estop(estop), .start(start), .man(man), .auto_md(auto_md),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_preset(cfg_preset), .ctrl(ctrl1), .busy(busy1));

    task automatic check(string name, logic [4*NUM_CH-1:0] got, logic [4*NUM_CH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Phases: 0 idle, 1 timing, 2 on, 3 off-hold; el counts ticks elapsed in the phase.
    task automatic model_step();
        logic [4*NUM_CH-1:0] w = '0;
        for (int d = 0; d < 2; d++) begin
            if (ena) begin
                bit tk = (ps[d] == pr[d] - 1);
                ps[d] = (ps[d] + 1) % pr[d];
                for (int i = 0; i < NUM_CH; i++) begin
                    if (estop || !(man[i] || auto_md[i])) begin
                        ph[d][i] = 0; el[d][i] = 0; mc[d][i] = 0;
                    end else if (man[i]) begin
                        ph[d][i] = 0; el[d][i] = 0; mc[d][i] = start[i];
                    end else begin
                        if (ph[d][i] == 0) begin
                            if (start[i]) begin ph[d][i] = (pre[d][i] == 0) ? 2 : 1; el[d][i] = 0; end
                        end else if (ph[d][i] == 1) begin
                            if (!start[i]) begin ph[d][i] = 0; el[d][i] = 0; end
                            else if (tk) begin
                                el[d][i]++;
                                if (el[d][i] >= pre[d][i]) begin ph[d][i] = 2; el[d][i] = 0; end
                            end
                        end else if (ph[d][i] == 2) begin
                            if (!start[i]) begin ph[d][i] = (HOLD > 0) ? 3 : 0; el[d][i] = 0; end
                        end else begin
                            if (start[i]) begin ph[d][i] = 2; el[d][i] = 0; end
                            else if (tk) begin
                                el[d][i]++;
                                if (el[d][i] >= HOLD) begin ph[d][i] = 0; el[d][i] = 0; end
                            end
                        end
                        mc[d][i] = (ph[d][i] >= 2);
                    end
                end
                if (cfg_we && int'(cfg_ch) < NUM_CH) pre[d][cfg_ch] = int'(cfg_preset);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                w[d*2*NUM_CH + i]          = mc[d][i];
                w[d*2*NUM_CH + NUM_CH + i] = (ph[d][i] == 1 || ph[d][i] == 3);
            end
        end
        exp_q.push_back(w);
    endtask

    task automatic cyc(bit e, bit es, logic [NUM_CH-1:0] s, logic [NUM_CH-1:0] m, logic [NUM_CH-1:0] a,
                       bit we, logic [1:0] ch, logic [CNT_W-1:0] p);
        @(negedge clk);
        ena = e; estop = es; start = s; man = m; auto_md = a; cfg_we = we; cfg_ch = ch; cfg_preset = p;
        model_step();
    endtask

    // Monitor: every edge the banks present registered outputs; compare against the oldest prediction.
    always @(posedge clk) begin
        #1;
        if (run && exp_q.size() > 0) check("outputs", {busy1, ctrl1, busy0, ctrl0}, exp_q.pop_front());
    end

    initial begin
        logic [NUM_CH-1:0] s = 0, m = 0, a = 0;
        for (int d = 0; d < 2; d++) begin
            ps[d] = 0;
            for (int i = 0; i < NUM_CH; i++) begin ph[d][i] = 0; el[d][i] = 0; pre[d][i] = DEF; mc[d][i] = 0; end
        end
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        check("reset_bank0", {6'b0, busy0, ctrl0}, '0);
        check("reset_bank1", {busy1, ctrl1, 6'b0}, '0);
        run = 1;
        repeat (30) cyc(1, 0, 3'b001, 3'b000, 3'b001, 0, 0, 0);
        repeat (5) cyc(1, 0, 3'b010, 3'b000, 3'b011, 0, 0, 0);
        repeat (10) cyc(1, 0, 3'b000, 3'b000, 3'b011, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(1, 0, k[0] ? 3'b100 : 3'b000, 3'b100, 3'b100, 0, 0, 0);
        cyc(1, 0, 3'b000, 3'b000, 3'b111, 1, 2'd2, 8'd0);
        cyc(1, 0, 3'b100, 3'b000, 3'b111, 1, 2'd3, 8'd1);
        repeat (3) cyc(1, 0, 3'b100, 3'b000, 3'b111, 0, 0, 0);
        cyc(1, 1, 3'b111, 3'b010, 3'b101, 0, 0, 0);
        repeat (4) cyc(1, 0, 3'b111, 3'b010, 3'b101, 0, 0, 0);
        repeat (20) cyc(1, 0, 3'b000, 3'b000, 3'b101, 0, 0, 0);
        s = 0; m = 0; a = 3'b111;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 24) == 0) s[i] = ~s[i];
                if ($urandom_range(0, 149) == 0) begin
                    m[i] = ($urandom_range(0, 3) == 0);
                    a[i] = ($urandom_range(0, 3) != 0);
                end
            end
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 119) == 0, s, m, a,
                $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 9)));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/plc_timer_bank.md
Name: plc_timer_bank

Overview:
- Multi-channel successor to the single-channel lathe start-delay controller.
- NUM_CH independent PLC-style channels, each with manual pass-through or auto on-delay timing.
- All channels share one prescaled timebase; presets are per-channel and runtime-programmable.
- Global E-stop overrides everything; sits between the operator panel I/O and the spindle/coolant/feed contactor drivers.

Parameters:
NUM_CH, 4, number of channels (1..16)
CNT_W, 16, preset/counter width in bits
PRESCALE, 50000, clk cycles per timer tick (>=1; 1 = tick every cycle)
DEFAULT_PRESET, 20, per-channel preset loaded at reset, in ticks
OFF_TICKS, 10, off-delay hold length in ticks (used only with PLC_OFFDLY_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
ena  in  1  global enable; low freezes all state, prescaler and outputs
estop  in  1  emergency stop, level, highest priority
start  in  NUM_CH  per-channel start request
man  in  NUM_CH  per-channel manual-mode select
auto_md  in  NUM_CH  per-channel auto-mode select
cfg_we  in  1  preset write strobe, one cycle
cfg_ch  in  CH_W  channel index; CH_W = max(1, clog2(NUM_CH))
cfg_preset  in  CNT_W  preset value to write
ctrl  out  NUM_CH  registered control outputs to the contactor drivers
busy  out  NUM_CH  channel is in TIMING or OFF_HOLD

Behaviour:
- Reset state: ctrl=0, busy=0, every channel in IDLE with count=0, presets=DEFAULT_PRESET, prescaler=0.
- All outputs are registered; nothing changes while ena=0 except through reset.
- Prescaler:
  - counts 0..PRESCALE-1 and wraps.
  - tick is high in the cycle the prescaler equals PRESCALE-1.
  - the prescaler is free-running and is not cleared by estop.
- Per-channel priority, evaluated every enabled edge: estop > man > auto_md > none.
- estop=1: all channels go to IDLE, count=0, ctrl=0 on the next edge. This includes manual channels.
- man[i]=1: ctrl[i] <= start[i] (one-cycle latency), state IDLE, count 0.
- Neither mode selected: IDLE, ctrl=0, count=0.
- auto_md[i]=1 state machine:
  - IDLE: when start=1, go to ON if preset=0, else go to TIMING with count=0. ctrl=0.
  - TIMING: ctrl=0. If start=0, go to IDLE and clear count. Otherwise on each tick count++; when count+1 >= preset, go to ON.
  - ON: ctrl=1. When start=0, go to IDLE with ctrl=0 on the next edge.
- Auto latency:
  - With PRESCALE=1, start first sampled high at edge E gives ctrl high after edge E+preset.
  - Otherwise ctrl rises on the preset-th tick strictly after edge E.
- Mode change mid-operation (auto to man or none) aborts timing immediately; count is cleared.
- Config writes:
  - cfg_we writes cfg_preset into channel cfg_ch on that edge.
  - cfg_ch >= NUM_CH is ignored.
  - A write during TIMING takes effect at the next tick comparison; a new preset <= count completes at that tick.
- The counter saturates by construction (compare uses >=), so there is no wrap-around.

Optional Feature:
- Macro PLC_OFFDLY_EN.
- Defined: when start drops, ON goes to OFF_HOLD.
  - OFF_HOLD keeps ctrl=1 and busy=1 and counts ticks.
  - After OFF_TICKS ticks it goes to IDLE with ctrl=0.
  - start=1 in OFF_HOLD returns to ON.
  - estop or a mode change exits immediately.
  - OFF_TICKS=0 behaves as not defined.
- Not defined: no OFF_HOLD state; ON goes to IDLE directly.

Test Plan:
- PRESCALE=1, ch0 preset 20, auto_md=1, start held from edge 10 -> ctrl[0] rises after edge 30; busy[0]=1 over edges 10..29.
- ch1 auto, start pulsed high for 5 cycles with preset 20 -> ctrl[1] never asserts; channel back in IDLE with count 0.
- ch2 man=1 and auto_md=1, start toggled -> ctrl[2] follows start with 1-cycle latency; busy[2]=0.
- All channels ON, estop asserted for 1 cycle -> all ctrl=0 next edge; manual channels resume following start afterwards.
- cfg write ch3 preset 0 then auto start -> ctrl[3]=1 one edge after start sampled; write with cfg_ch=NUM_CH -> no preset changes.
- With PLC_OFFDLY_EN, OFF_TICKS=10, PRESCALE=4: start drops in ON -> ctrl stays high for 10 ticks (40 cycles) then 0; start re-asserted mid-hold -> stays ON.
